// File: rtl/router_pkg.sv
// +----------------------------------------------------------------------------+
// | router_pkg: constants shared by the router pipeline controllers.           |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

package router_pkg;

  localparam int PACKET_W  = 14;
  localparam int MAX_DELAY = 15;

endpackage : router_pkg

`default_nettype wire

// File: rtl/click_delay_line.sv
// +----------------------------------------------------------------------------+
// | click_delay_line: 1-bit DELAY-deep shift register (matched forward delay). |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module click_delay_line
  import router_pkg::*;
#(
  parameter int DELAY = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  generate
    if (DELAY == 0) begin : g_bypass
      // Zero delay: the request follows the phase register directly.
      logic unused_w;
      assign unused_w = clk ^ rst;
      assign q_o      = d_i;
    end else begin : g_shift
      logic [DELAY-1:0] sr_q;
      logic [DELAY-1:0] sr_d;

      always_comb begin
        sr_d    = sr_q;
        sr_d[0] = d_i;
        for (int i = 1; i < DELAY; i++) begin
          sr_d[i] = sr_q[i-1];
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          sr_q <= '0;
        end else begin
          sr_q <= sr_d;
        end
      end

      assign q_o = sr_q[DELAY-1];
    end
  endgenerate

endmodule : click_delay_line

`default_nettype wire

// File: rtl/click_controller_sync.sv
// +----------------------------------------------------------------------------+
// | click_controller_sync: clocked two-phase bundled-data pipeline stage.      |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module click_controller_sync
  import router_pkg::*;
#(
  parameter int WIDTH = PACKET_W,
  parameter int DELAY = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             lreq,
  output logic             lack,
  input  logic [WIDTH-1:0] ldata,
  output logic             rreq,
  input  logic             rack,
  output logic [WIDTH-1:0] rdata
);

  logic             p_q;
  logic             p_d;
  logic [WIDTH-1:0] rdata_q;
  logic [WIDTH-1:0] rdata_d;
  logic             rreq_w;
  logic             pending_w;
  logic             free_w;
  logic             fire_w;

  // A token may enter only once the previous one has been offered and acked.
  assign pending_w = (lreq != p_q);
  assign free_w    = (rack == p_q) && (rreq_w == p_q);
  assign fire_w    = pending_w && free_w && !rst;

  always_comb begin
    p_d     = p_q;
    rdata_d = rdata_q;
    if (fire_w) begin
      p_d     = ~p_q;
      rdata_d = ldata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      p_q     <= 1'b0;
      rdata_q <= '0;
    end else begin
      p_q     <= p_d;
      rdata_q <= rdata_d;
    end
  end

  click_delay_line #(
    .DELAY (DELAY)
  ) u_delay (
    .clk (clk),
    .rst (rst),
    .d_i (p_q),
    .q_o (rreq_w)
  );

  assign lack  = p_q;
  assign rreq  = rreq_w;
  assign rdata = rdata_q;

endmodule : click_controller_sync

`default_nettype wire

// File: tb/tb_click_controller_sync.sv
// +----------------------------------------------------------------------------+
// | tb_click_controller_sync: directed bench for DELAY=2 and DELAY=0 stages.   |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_click_controller_sync;

  localparam int W = 14;

  logic         clk;
  logic         rst;

  logic         a_lreq;
  logic         a_lack;
  logic [W-1:0] a_ldata;
  logic         a_rreq;
  logic         a_rack;
  logic [W-1:0] a_rdata;

  logic         b_lreq;
  logic         b_lack;
  logic [W-1:0] b_ldata;
  logic         b_rreq;
  logic         b_rack;
  logic [W-1:0] b_rdata;

  int vectors;
  int miscompares;

  click_controller_sync #(.WIDTH(W), .DELAY(2)) u_dut_d2 (
    .clk   (clk),
    .rst   (rst),
    .lreq  (a_lreq),
    .lack  (a_lack),
    .ldata (a_ldata),
    .rreq  (a_rreq),
    .rack  (a_rack),
    .rdata (a_rdata)
  );

  click_controller_sync #(.WIDTH(W), .DELAY(0)) u_dut_d0 (
    .clk   (clk),
    .rst   (rst),
    .lreq  (b_lreq),
    .lack  (b_lack),
    .ldata (b_ldata),
    .rreq  (b_rreq),
    .rack  (b_rack),
    .rdata (b_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int sent;
    int lack_tog;
    int rreq_tog;
    logic prev_lack;
    logic prev_rreq;
    bit done;

    vectors     = 0;
    miscompares = 0;

    // Reset with both handshakes held high
    rst     = 1'b1;
    a_lreq  = 1'b1;
    a_rack  = 1'b1;
    a_ldata = 14'h3FFF;
    b_lreq  = 1'b0;
    b_rack  = 1'b0;
    b_ldata = '0;
    tick();
    tick();
    chk("rst_lack",  {31'd0, a_lack}, 32'd0);
    chk("rst_rreq",  {31'd0, a_rreq}, 32'd0);
    chk("rst_rdata", {18'd0, a_rdata}, 32'd0);
    chk("rst_b_lack", {31'd0, b_lack}, 32'd0);

    rst    = 1'b0;
    a_lreq = 1'b0;
    a_rack = 1'b0;
    tick();
    chk("idle_lack", {31'd0, a_lack}, 32'd0);
    chk("idle_rreq", {31'd0, a_rreq}, 32'd0);

    // Single token, DELAY=2
    a_ldata = 14'h1A5;
    a_lreq  = 1'b1;
    tick();
    chk("tok1_lack",  {31'd0, a_lack}, 32'd1);
    chk("tok1_rdata", {18'd0, a_rdata}, 32'h1A5);
    chk("tok1_rreq_c0", {31'd0, a_rreq}, 32'd0);
    tick();
    chk("tok1_rreq_c1", {31'd0, a_rreq}, 32'd0);
    tick();
    chk("tok1_rreq_c2", {31'd0, a_rreq}, 32'd1);

    // Backpressure: second token waits for rack
    a_ldata = 14'h0F0;
    a_lreq  = 1'b0;
    tick();
    chk("bp_lack_a",  {31'd0, a_lack}, 32'd1);
    chk("bp_rdata_a", {18'd0, a_rdata}, 32'h1A5);
    tick();
    chk("bp_lack_b",  {31'd0, a_lack}, 32'd1);
    chk("bp_rdata_b", {18'd0, a_rdata}, 32'h1A5);
    a_rack = 1'b1;
    tick();
    chk("bp_fire_lack",  {31'd0, a_lack}, 32'd0);
    chk("bp_fire_rdata", {18'd0, a_rdata}, 32'h0F0);
    tick();
    tick();
    chk("bp_rreq_back", {31'd0, a_rreq}, 32'd0);
    a_rack = 1'b0;
    tick();

    // Streaming 8 tokens with a sink that echoes rreq one cycle later
    sent      = 0;
    lack_tog  = 0;
    rreq_tog  = 0;
    prev_lack = a_lack;
    prev_rreq = a_rreq;
    done      = 1'b0;
    a_ldata   = W'(sent);
    a_lreq    = ~a_lreq;
    sent      = 1;
    for (int cyc = 0; cyc < 200 && !done; cyc++) begin
      tick();
      if (a_lack != prev_lack) begin
        chk("stream_rdata_at_lack", {18'd0, a_rdata}, lack_tog);
        lack_tog++;
        prev_lack = a_lack;
      end
      if (a_rreq != prev_rreq) begin
        chk("stream_rdata_at_rreq", {18'd0, a_rdata}, rreq_tog);
        rreq_tog++;
        prev_rreq = a_rreq;
      end
      if (a_rreq != a_rack) a_rack = a_rreq;
      if (sent < 8 && a_lack == a_lreq) begin
        a_ldata = W'(sent);
        a_lreq  = ~a_lreq;
        sent++;
      end
      if (lack_tog == 8 && rreq_tog == 8 && a_rack == a_rreq) done = 1'b1;
    end
    chk("stream_lack_toggles", lack_tog, 32'd8);
    chk("stream_rreq_toggles", rreq_tog, 32'd8);
    tick();

    // DELAY=0 stage: lack and rreq move together
    b_ldata = 14'h3C3;
    b_lreq  = 1'b1;
    tick();
    chk("d0_lack",  {31'd0, b_lack}, 32'd1);
    chk("d0_rreq",  {31'd0, b_rreq}, 32'd1);
    chk("d0_rdata", {18'd0, b_rdata}, 32'h3C3);
    b_rack  = 1'b1;
    b_ldata = 14'h0A5;
    b_lreq  = 1'b0;
    tick();
    chk("d0_lack2",  {31'd0, b_lack}, 32'd0);
    chk("d0_rreq2",  {31'd0, b_rreq}, 32'd0);
    chk("d0_rdata2", {18'd0, b_rdata}, 32'h0A5);

    // Mid-token reset on the DELAY=2 stage
    a_ldata = 14'h2AA;
    a_lreq  = 1'b1;
    tick();
    chk("mid_fire_rdata", {18'd0, a_rdata}, 32'h2AA);
    tick();
    tick();
    chk("mid_rreq_pending", {31'd0, a_rreq}, 32'd1);
    rst    = 1'b1;
    a_lreq = 1'b0;
    a_rack = 1'b0;
    tick();
    chk("mid_rst_lack",  {31'd0, a_lack}, 32'd0);
    chk("mid_rst_rreq",  {31'd0, a_rreq}, 32'd0);
    chk("mid_rst_rdata", {18'd0, a_rdata}, 32'd0);
    rst = 1'b0;
    tick();
    a_ldata = 14'h155;
    a_lreq  = 1'b1;
    tick();
    chk("post_lack",  {31'd0, a_lack}, 32'd1);
    chk("post_rdata", {18'd0, a_rdata}, 32'h155);
    tick();
    tick();
    chk("post_rreq", {31'd0, a_rreq}, 32'd1);

    // lreq and rack toggle sampled on the same edge: both honoured
    a_ldata = 14'h2F0;
    a_lreq  = 1'b0;
    a_rack  = 1'b1;
    tick();
    chk("same_edge_lack",  {31'd0, a_lack}, 32'd0);
    chk("same_edge_rdata", {18'd0, a_rdata}, 32'h2F0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_click_controller_sync

`default_nettype wire
